// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: word type, field positions and the adder pipeline depth.
package fp16_pkg;

    typedef logic [15:0] fp16_t;

    localparam int unsigned SIGN_BIT = 15;
    localparam int unsigned EXP_MSB  = 14;
    localparam int unsigned EXP_LSB  = 10;
    localparam int unsigned MAN_W    = 10;

    localparam int unsigned FP16_ADD_LATENCY = 4;

    typedef struct packed {
        logic                       sign;
        logic [EXP_MSB-EXP_LSB:0]   exponent;
        logic [MAN_W-1:0]           mantissa;
    } fp16_fields_t;

    function automatic fp16_fields_t fp16_unpack(input fp16_t value);
        fp16_fields_t f;
        f.sign     = value[SIGN_BIT];
        f.exponent = value[EXP_MSB:EXP_LSB];
        f.mantissa = value[MAN_W-1:0];
        return f;
    endfunction

endpackage

// File: rtl/fp16_result_fifo.sv
// Circular result buffer with fall-through head; storage is deliberately not reset.
module fp16_result_fifo
    import fp16_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  fp16_t         i_push_data,
    input  logic          i_pop,
    output fp16_t         o_head,
    output logic          o_valid,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    fp16_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;

    // A pop request against an empty buffer is simply dropped.
    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_push) begin
            assert (r_count != L_FULL);
        end
    end

endmodule

// File: rtl/fp16_add_sequencer.sv
// Valid/ready front end for the stall-free FP16 adder: credit gating, result tagging and capture.
module fp16_add_sequencer
    import fp16_pkg::*;
#(
    parameter  int unsigned ADD_LATENCY = FP16_ADD_LATENCY,
    parameter  int unsigned FIFO_DEPTH  = 8,
    localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1
)
(
    input  logic          clock_80,
    input  logic          reset_80,
    input  logic          in_valid,
    output logic          in_ready,
    input  fp16_t         in_a,
    input  fp16_t         in_b,
    output fp16_t         add_a_80,
    output fp16_t         add_b_80,
    input  fp16_t         add_sum_80,
    output logic          out_valid,
    input  logic          out_ready,
    output fp16_t         out_sum,
    output logic [CW-1:0] occupancy
);

    localparam logic [CW-1:0] L_DEPTH = CW'(FIFO_DEPTH);

    logic [ADD_LATENCY-1:0] r_vsr;
    logic [CW-1:0]          r_inflight;
    logic [CW-1:0]          w_fifo_count;
    logic [CW-1:0]          w_occ;
    logic                   w_issue;
    logic                   w_capture;
    logic                   w_fifo_valid;
    fp16_t                  w_fifo_head;

    // Every issued pair already owns a FIFO slot, so the adder can never outrun the buffer.
    assign w_occ     = r_inflight + w_fifo_count;
    assign in_ready  = (w_occ < L_DEPTH);
    assign occupancy = w_occ;

    assign w_issue   = in_valid && in_ready;
    assign add_a_80  = w_issue ? in_a : '0;
    assign add_b_80  = w_issue ? in_b : '0;

    assign w_capture = r_vsr[ADD_LATENCY-1];

    always_ff @(posedge clock_80) begin
        if (reset_80) begin
            r_vsr      <= '0;
            r_inflight <= '0;
        end else begin
            r_vsr[0] <= w_issue;
            for (int unsigned k = 1; k < ADD_LATENCY; k++) begin
                r_vsr[k] <= r_vsr[k-1];
            end
            case ({w_issue, w_capture})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    fp16_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk         (clock_80),
        .rst         (reset_80),
        .i_push      (w_capture),
        .i_push_data (add_sum_80),
        .i_pop       (out_ready),
        .o_head      (w_fifo_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count)
    );

    assign out_valid = w_fifo_valid;
    assign out_sum   = w_fifo_head;

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// Scoreboard bench: XOR adder stand-in, transaction-level model of credit and ordering.
module tb_fp16_add_sequencer;
    import fp16_pkg::*;

    localparam int unsigned L  = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clock_80 = 1'b0;
    logic          reset_80;
    logic          in_valid;
    logic          in_ready;
    fp16_t         in_a;
    fp16_t         in_b;
    fp16_t         add_a_80;
    fp16_t         add_b_80;
    fp16_t         add_sum_80;
    logic          out_valid;
    logic          out_ready;
    fp16_t         out_sum;
    logic [CW-1:0] occupancy;

    always #5 clock_80 = ~clock_80;

    fp16_add_sequencer #(
        .ADD_LATENCY (L),
        .FIFO_DEPTH  (D)
    ) dut (
        .clock_80   (clock_80),
        .reset_80   (reset_80),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_a_80   (add_a_80),
        .add_b_80   (add_b_80),
        .add_sum_80 (add_sum_80),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .occupancy  (occupancy)
    );

    // Adder stand-in: L registers, no reset, result = a ^ b.
    fp16_t pipe [L];
    always @(posedge clock_80) begin
        pipe[0] <= add_a_80 ^ add_b_80;
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign add_sum_80 = pipe[L-1];

    typedef struct {
        fp16_t d;
        int    t;
    } item_t;

    item_t sb[$];
    int    cyc        = 0;
    bit    armed      = 1'b0;
    bit    m_ready    = 1'b1;
    int    checks     = 0;
    int    errors     = 0;
    int    dut_issues = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Model update on each edge: every accepted pair owns a credit until it is popped.
    initial forever begin
        @(posedge clock_80);
        cyc++;
        if (reset_80) begin
            sb.delete();
            armed = 1'b1;
        end else if (in_valid && m_ready) begin
            sb.push_back('{d: in_a ^ in_b, t: cyc});
        end
    end

    // Monitor: compares the DUT against the model mid-cycle and retires popped results.
    initial forever begin
        bit    ev;
        fp16_t ea;
        fp16_t eb;
        @(negedge clock_80);
        if (armed) begin
            ev      = (sb.size() > 0) && (sb[0].t + L <= cyc);
            m_ready = (sb.size() < D);
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
            chk("occupancy", 32'(occupancy), 32'(sb.size()));
            chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
            ea = (in_valid && m_ready) ? in_a : 16'h0000;
            eb = (in_valid && m_ready) ? in_b : 16'h0000;
            chk("add_a", 32'(add_a_80), 32'(ea));
            chk("add_b", 32'(add_b_80), 32'(eb));
            if (ev && out_valid) chk("out_sum", 32'(out_sum), 32'(sb[0].d));
            if (ev && out_ready) void'(sb.pop_front());
            if (in_valid && in_ready) dut_issues++;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_80);
            #1;
        end
    endtask

    initial begin
        int base;
        reset_80  = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        step(3);
        reset_80 = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_add_a", 32'(add_a_80), 32'd0);

        // Single pair
        in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000;
        step(1);
        in_valid = 1'b0; in_a = 16'h1234; in_b = 16'h5678;
        chk("single_occ1", 32'(occupancy), 32'd1);
        step(3);
        chk("single_notyet", {31'b0, out_valid}, 32'd0);
        step(1);
        chk("single_valid", {31'b0, out_valid}, 32'd1);
        chk("single_sum", 32'(out_sum), 32'h7C00);
        step(1);
        chk("single_occ0", 32'(occupancy), 32'd0);
        step(3);

        // Back-to-back with out_ready high
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_a = fp16_t'(i); in_b = 16'h0000;
            chk("b2b_ready", {31'b0, in_ready}, 32'd1);
            step(1);
        end
        in_valid = 1'b0;
        step(8);

        // Backpressure: credit must stop issue at exactly D
        out_ready = 1'b0;
        base = dut_issues;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_a = fp16_t'($urandom); in_b = fp16_t'($urandom);
            step(1);
        end
        in_valid = 1'b0;
        step(6);
        chk("bp_issues", 32'(dut_issues - base), 32'd8);
        chk("bp_full", 32'(occupancy), 32'd8);
        chk("bp_blocked", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("bp_credit", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step(10);

        // Simultaneous push and pop with three results waiting
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = fp16_t'(16'hA000 + i); in_b = 16'h0F0F;
            step(1);
        end
        in_valid = 1'b0;
        step(5);
        chk("pp_count3", 32'(occupancy), 32'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 6); in_a = fp16_t'(16'hB000 + i); in_b = 16'h00FF;
            step(1);
        end
        in_valid = 1'b0;
        step(10);

        // Reset with 3 in flight and 2 captured
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = fp16_t'(16'hDEAD + i); in_b = 16'h1111;
            step(1);
        end
        in_valid = 1'b0;
        step(1);
        chk("prerst_occ", 32'(occupancy), 32'd5);
        chk("prerst_valid", {31'b0, out_valid}, 32'd1);
        reset_80 = 1'b1;
        step(1);
        reset_80 = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_occupancy", 32'(occupancy), 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step(10);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_a      = fp16_t'($urandom);
            in_b      = fp16_t'($urandom);
            step(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(20);
        chk("final_occupancy", 32'(occupancy), 32'd0);
        chk("final_out_valid", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_add_sequencer.md
# fp16_add_sequencer

Flow-control stage for the 4-stage pipelined FP16 adder, which has no valid, no stall and no reset. It accepts operand pairs on a valid/ready handshake and drives them into the adder. A latency-matched valid shift register tags each result as it leaves the adder, and results are captured into a result FIFO that drains on a second valid/ready port. Credit accounting guarantees the FIFO never overflows, because the adder cannot be stalled.

## Interface
- ADD_LATENCY, 4: rising edges from operand capture until `final_sum` is valid; the first edge is the one that samples the operands.
- FIFO_DEPTH, 8: result FIFO entries; power of two, ≥ 2.
- clock_80  input  1  single clock; all state changes on rising edge.
- reset_80  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept a pair this cycle.
- in_a  input  16  FP16 operand A.
- in_b  input  16  FP16 operand B.
- add_a_80  output  16  to adder `input_1`.
- add_b_80  output  16  to adder `input_2`.
- add_sum_80  input  16  from adder `final_sum`.
- out_valid  output  1  result available at FIFO head.
- out_ready  input  1  consumer accepts head.
- out_sum  output  16  FIFO head value.
- occupancy  output  $clog2(FIFO_DEPTH)+1  in-flight count plus FIFO count.

## Operation
- Issue: `issue = in_valid && in_ready`.
  - `add_a_80`/`add_b_80` = `in_a`/`in_b` when `issue`, else 16'h0000.
  - These are combinational, so the adder samples them on the issue edge.
- Credit:
  - `in_ready = (inflight + fifo_count) < FIFO_DEPTH`, computed from registered state only.
  - `in_ready` never depends on `in_valid` or `out_ready`.
  - A pop in cycle N frees its credit from cycle N+1.
- Tag shift register `vsr[ADD_LATENCY-1:0]`:
  - `vsr[0] <= issue`; `vsr[k] <= vsr[k-1]`.
  - `inflight` is the popcount of `vsr`, kept as a register updated by +issue − `vsr[ADD_LATENCY-1]`.
- Capture: when `vsr[ADD_LATENCY-1]` = 1, push `add_sum_80` into the FIFO at `wr_ptr`.
- FIFO:
  - Circular buffer with `wr_ptr`/`rd_ptr` of $clog2(FIFO_DEPTH) bits that wrap naturally.
  - `fifo_count` is $clog2(FIFO_DEPTH)+1 bits.
  - `out_valid = fifo_count != 0`; `out_sum = mem[rd_ptr]` (fall-through read).
  - Pop = `out_valid && out_ready`.
- Simultaneous events:
  - Push and pop in the same cycle with count > 0: count unchanged, both pointers advance.
  - Push into an empty FIFO: `out_valid` rises the next cycle. There is no same-cycle bypass.
  - Pop with `out_valid` = 0: ignored.
- Overflow (push with `fifo_count` = FIFO_DEPTH) is unreachable by construction; the design carries an assertion for it.
- Ordering: results leave strictly in issue order.
- Reset:
  - `vsr`, `inflight`, pointers and `fifo_count` are cleared to 0.
  - Results still in the adder pipeline at reset are discarded, because their tags are cleared.
  - FIFO storage is not reset.

## Timing
- Reset values:
  - `in_ready` = 1 and `out_valid` = 0.
  - `occupancy` = 0 and `add_a_80`/`add_b_80` = 0 (assuming `in_valid` is low).
  - `out_sum` is don't-care while `out_valid` = 0.
- Latency:
  - Issue at edge N: the result is pushed at edge N+ADD_LATENCY and `out_valid` is 1 after it.
  - Minimum issue-to-`out_valid` latency is therefore ADD_LATENCY+1 cycles.
- Throughput: one issue per cycle while credit remains. Sustained one per cycle with `out_ready` held high.
- `reset_80` asserted mid-stream takes effect at that edge. The cycle after, `in_ready` = 1 and `out_valid` = 0.

## Structure
- Shared package `fp16_pkg`:
  - `typedef logic [15:0] fp16_t`.
  - Field constants: SIGN_BIT=15, EXP_MSB=14, EXP_LSB=10, MAN_W=10.
  - `FP16_ADD_LATENCY = 4`, used as the ADD_LATENCY default.
- One sub-module, `fp16_result_fifo`: parameterized FIFO with push, pop, count, fall-through head.
- The sequencer top holds the handshake, credit and tag logic.
- Integration instantiates the sequencer and the adder side by side.

## Test plan
The bench adder model is an ADD_LATENCY-register pipe returning `a ^ b`, with no reset.
- Single pair:
  - Stimulus: in_a=16'h3C00, in_b=16'h4000 at edge 0, `out_ready` high.
  - Required: `out_valid` rises after edge 4 with `out_sum` = 16'h7C00; `occupancy` reads 1 then 0.
- Back-to-back, `out_ready` held high:
  - Stimulus: 16 issues with in_a=i, in_b=0.
  - Required: `in_ready` never drops; outputs 0..15 appear in order on consecutive cycles.
- Backpressure:
  - Stimulus: `out_ready` = 0, `in_valid` held high.
  - Required: exactly 8 issues accepted, then `in_ready` = 0.
  - Required: `fifo_count` reaches 8 with no overflow.
  - Then one pop restores `in_ready` one cycle later.
- Simultaneous push and pop at `fifo_count` = 3: count stays 3 and the data order is preserved.
- Reset mid-flight:
  - Stimulus: assert `reset_80` with 3 results in flight and 2 in the FIFO.
  - Required: the next cycle has `out_valid` = 0, `occupancy` = 0 and `in_ready` = 1.
  - Required: no stale result ever appears on the output afterwards.
